// File: rtl/fsmc_bus_slave_bl.sv
`default_nettype none
// ============================================================================
// Module      : fsmc_bus_slave_bl
// Description : Clocked FSMC/SRAM-style bus slave with byte-lane write masking,
//               a rd_valid read handshake bounded by a timeout, and an optional
//               NWAIT stall output enabled by the FSMC_NWAIT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module fsmc_bus_slave_bl #(
    parameter int              ADRW        = 8,
    parameter int              DATW        = 16,
    parameter int              SYNC_STAGES = 2,
    parameter int              RD_TIMEOUT  = 15,
    parameter logic [DATW-1:0] ERR_DATA    = 16'hDEAD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                aNE,
    input  logic                aNOE,
    input  logic                aNWE,
    input  logic [DATW/8-1:0]   aNBL,
    input  logic [ADRW-1:0]     aAn,
    input  logic [DATW-1:0]     aDn,
    output logic [ADRW-1:0]     r_adr,
    output logic [ADRW-1:0]     w_adr,
    output logic                do_read,
    input  logic [DATW-1:0]     read_data,
    input  logic                rd_valid,
    output logic                do_write,
    output logic [DATW-1:0]     w_data,
    output logic [DATW/8-1:0]   w_be,
    output logic                io_output,
    output logic [DATW-1:0]     io_data,
    output logic                rd_timeout
`ifdef FSMC_NWAIT_EN
    ,
    output logic                aNWAIT
`endif
);

    localparam int         c_NBW      = DATW / 8;
    localparam logic [7:0] c_TMO_LAST = 8'(RD_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_WRITE    = 4'b0010,
        S_RD_WAIT  = 4'b0100,
        S_RD_DRIVE = 4'b1000
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0]            r_ne_sync;
    logic [SYNC_STAGES-1:0]            r_noe_sync;
    logic [SYNC_STAGES-1:0]            r_nwe_sync;
    logic [SYNC_STAGES-1:0][c_NBW-1:0] r_nbl_sync;
    logic [7:0]                        r_tmo_cnt;

    logic             w_sne;
    logic             w_snoe;
    logic             w_snwe;
    logic [c_NBW-1:0] w_snbl;
    logic             w_sel;
    logic             w_ld_write;
    logic             w_ld_read;
    logic             w_ld_valid;
    logic             w_ld_err;

    // Presetting to 1 keeps all strobes inactive coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ne_sync  <= '1;
            r_noe_sync <= '1;
            r_nwe_sync <= '1;
            r_nbl_sync <= '1;
        end else begin
            r_ne_sync  <= {r_ne_sync[SYNC_STAGES-2:0], aNE};
            r_noe_sync <= {r_noe_sync[SYNC_STAGES-2:0], aNOE};
            r_nwe_sync <= {r_nwe_sync[SYNC_STAGES-2:0], aNWE};
            r_nbl_sync <= {r_nbl_sync[SYNC_STAGES-2:0], aNBL};
        end
    end

    assign w_sne  = r_ne_sync[SYNC_STAGES-1];
    assign w_snoe = r_noe_sync[SYNC_STAGES-1];
    assign w_snwe = r_nwe_sync[SYNC_STAGES-1];
    assign w_snbl = r_nbl_sync[SYNC_STAGES-1];
    assign w_sel  = ~w_sne;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_ld_write = 1'b0;
        w_ld_read  = 1'b0;
        w_ld_valid = 1'b0;
        w_ld_err   = 1'b0;
        io_output  = (r_state == S_RD_DRIVE) & w_sel & ~w_snoe;
        case (r_state)
            S_IDLE: begin
                // Write takes priority when both NOE and NWE are low.
                if (w_sel & ~w_snwe) begin
                    w_ld_write = 1'b1;
                    w_next     = S_WRITE;
                end else if (w_sel & ~w_snoe) begin
                    w_ld_read = 1'b1;
                    w_next    = S_RD_WAIT;
                end
            end
            S_WRITE: begin
                if (!(w_sel & ~w_snwe)) begin
                    w_next = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                // Host abort beats any late data; rd_valid beats the timeout.
                if (w_sne | w_snoe) begin
                    w_next = S_IDLE;
                end else if (rd_valid) begin
                    w_ld_valid = 1'b1;
                    w_next     = S_RD_DRIVE;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_ld_err = 1'b1;
                    w_next   = S_RD_DRIVE;
                end
            end
            S_RD_DRIVE: begin
                if (!(w_sel & ~w_snoe)) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            do_write   <= 1'b0;
            do_read    <= 1'b0;
            rd_timeout <= 1'b0;
            w_adr      <= '0;
            w_data     <= '0;
            w_be       <= '0;
            r_adr      <= '0;
            io_data    <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            do_write   <= w_ld_write;
            do_read    <= w_ld_read;
            rd_timeout <= w_ld_err;
            if (w_ld_write) begin
                w_adr  <= aAn;
                w_data <= aDn;
                w_be   <= ~w_snbl;
            end
            if (w_ld_read) begin
                r_adr     <= aAn;
                r_tmo_cnt <= '0;
            end else if (r_state == S_RD_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (w_ld_valid) begin
                io_data <= read_data;
            end else if (w_ld_err) begin
                io_data <= ERR_DATA;
            end
        end
    end

`ifdef FSMC_NWAIT_EN
    // Low exactly while the slave sits in RD_WAIT waiting for data.
    always_ff @(posedge clk) begin
        if (rst) begin
            aNWAIT <= 1'b1;
        end else begin
            aNWAIT <= (w_next != S_RD_WAIT);
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/fsmc_bus_slave_bl.md
Name: fsmc_bus_slave_bl

Overview:
- Next-generation clocked FSMC/SRAM-style bus slave that sits between the STM32 FSMC pins and the FPGA register/char-buffer logic.
- Widths are parametrised; adds byte-lane (NBL) write masking and a read handshake with the register file (rd_valid) bounded by a timeout counter.
- Adds an optional NWAIT stall output.
- Async strobes are resynchronised to clk (the PLL clock); address and data are sampled unsynchronised once strobes are stable.

Parameters:
- ADRW, 8, address width.
- DATW, 16, data width; must be a multiple of 8.
- SYNC_STAGES, 2, synchroniser depth for aNE/aNOE/aNWE/aNBL; minimum 2.
- RD_TIMEOUT, 15, max cycles to wait for rd_valid after do_read; range 1..255.
- ERR_DATA, 16'hDEAD, value returned on a read timeout; width DATW.

Ports:
- clk  in  1  system clock (PLL output).
- rst  in  1  synchronous active-high reset.
- aNE  in  1  async chip select, active low.
- aNOE  in  1  async output enable, active low.
- aNWE  in  1  async write enable, active low.
- aNBL  in  DATW/8  async byte-lane enables, active low.
- aAn  in  ADRW  async address.
- aDn  in  DATW  async data from the pad input.
- r_adr  out  ADRW  latched read address.
- w_adr  out  ADRW  latched write address.
- do_read  out  1  one-cycle read request.
- read_data  in  DATW  register read data.
- rd_valid  in  1  read_data valid; sampled only in RD_WAIT.
- do_write  out  1  one-cycle write strobe.
- w_data  out  DATW  latched write data.
- w_be  out  DATW/8  active-high byte enables (inverted, latched aNBL).
- io_output  out  1  pad output enable.
- io_data  out  DATW  data to drive on the pad.
- rd_timeout  out  1  one-cycle pulse on read timeout.
- aNWAIT  out  1  present only with FSMC_NWAIT_EN.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset state:
  - state = IDLE.
  - do_read, do_write, io_output, rd_timeout = 0.
  - r_adr, w_adr, w_data, io_data = 0; w_be = 0.
  - Synchroniser flops preset to 1 (strobes inactive); aNWAIT = 1.
- Synchronised strobes: sNE, sNOE, sNWE, with latency SYNC_STAGES cycles. In the rules below, "sel" = ~sNE.
- States: IDLE, WRITE, RD_WAIT, RD_DRIVE (one-hot).
- IDLE, write detected (sel & ~sNWE):
  - latch w_adr <= aAn, w_data <= aDn, w_be <= ~sNBL;
  - do_write = 1 on the next cycle for exactly 1 cycle;
  - go to WRITE.
- IDLE, read detected (sel & ~sNOE & sNWE):
  - latch r_adr <= aAn; do_read pulses for 1 cycle;
  - clear the timeout counter; go to RD_WAIT.
- IDLE, NOE and NWE both low: write wins; the read is ignored.
- WRITE: stay while sel & ~sNWE; otherwise go to IDLE. No second do_write within one strobe.
- RD_WAIT:
  - rd_valid=1: io_data <= read_data; go to RD_DRIVE.
  - rd_valid=0: counter increments each cycle.
  - When the counter reaches RD_TIMEOUT: io_data <= ERR_DATA; rd_timeout pulses 1 cycle; go to RD_DRIVE.
  - rd_valid wins if it coincides with timeout.
  - sNE or sNOE rising in RD_WAIT (host aborted): go to IDLE; no pad drive; io_data not updated.
- RD_DRIVE: io_output = RD_DRIVE & sel & ~sNOE (combinational on registered signals). When either strobe goes high: io_output drops in the same cycle and the next state is IDLE.
- Minimum read latency from sNOE low to io_output: 2 cycles with rd_valid tied high.
- Back-to-back transactions: a new strobe edge is only recognised from IDLE. At least one cycle with strobes high is required between accesses.
- Reset mid-transaction: next cycle state = IDLE and io_output = 0. A pending do_read/do_write pulse is cancelled.

Optional Feature:
- Macro FSMC_NWAIT_EN.
- Defined:
  - aNWAIT port exists, registered.
  - Driven 0 from the cycle after read detection until the cycle io_data is loaded; 1 otherwise, including during writes.
  - Host may then use FSMC wait mode.
- Undefined: port absent; host must program a DATAST long enough to cover SYNC_STAGES+2+RD_TIMEOUT cycles.

Test Plan:
- Write: aAn=8'h12, aDn=16'hA55A, aNBL=2'b00, NE/NWE low for 6 cycles -> exactly one do_write pulse; w_adr=8'h12, w_data=16'hA55A, w_be=2'b11.
- Byte write: aNBL=2'b10, aDn=16'h00C3 -> w_be=2'b01, do_write once.
- Read: aAn=8'h05, rd_valid asserted 3 cycles after do_read with read_data=16'h1234 -> io_output=1 while NOE low, io_data=16'h1234; io_output=0 the cycle sNOE is seen high.
- Timeout: rd_valid held 0, RD_TIMEOUT=4 -> rd_timeout pulse 4 cycles after entering RD_WAIT; io_data=16'hDEAD.
- Abort/reset: NOE released during RD_WAIT -> io_output never asserts, state IDLE. rst pulsed in RD_DRIVE -> io_output=0 next cycle.
- FSMC_NWAIT_EN: read with rd_valid delayed 5 cycles -> aNWAIT low for exactly the RD_WAIT window; aNWAIT stays 1 throughout a write.
